// File: rtl/ip2_scanout_capture_if.sv
// ip2_scanout_capture_if: valid/ready word handshake from the scan-out capture
// block to the downstream capture buffer.
interface ip2_scanout_capture_if #(parameter int WORD_W = 32);
   logic [WORD_W-1:0] word_data;
   logic              word_valid;
   logic              word_ready;
   modport master (output word_data, word_valid, input word_ready);
   modport slave (input word_data, word_valid, output word_ready);
endinterface

// File: rtl/ip2_scanout_capture.sv
// ip2_scanout_capture: samples the ASIC scan_out stream once per bxclk period,
// packs bits LSB-first into words and counts mismatches against the expected bits.
module ip2_scanout_capture #(
   parameter int WORD_W = 32,
   parameter int CNT_W  = 11,
   parameter int PH_W   = 6
) (
   input  logic                 clk,
   input  logic                 reset_not,
   input  logic                 enable,
   input  logic [PH_W-1:0]      clk_counter,
   input  logic [PH_W-1:0]      sample_phase,
   input  logic                 capture_start,
   input  logic [CNT_W-1:0]     bit_cnt_max,
   input  logic                 scan_out,
   input  logic                 expected_bit,
   ip2_scanout_capture_if.master wb,
   output logic                 capture_busy,
   output logic                 capture_done,
   output logic                 overflow,
   output logic [CNT_W-1:0]     bit_cnt,
   output logic [CNT_W-1:0]     mismatch_cnt,
   output logic [1:0]           state
);
   localparam int IW = $clog2(WORD_W);
   typedef enum logic [1:0] {IDLE = 2'b00, CAPTURE = 2'b01, DONE = 2'b10} state_t;
   state_t            st;
   logic [WORD_W-1:0] assembly, word;
   logic [IW-1:0]     idx;
   logic              sample, last, push;
   assign state        = st;
   assign capture_busy = st == CAPTURE;
   assign idx          = bit_cnt[IW-1:0];
   assign sample       = st == CAPTURE && clk_counter == sample_phase;
   assign last         = bit_cnt == bit_cnt_max;
   assign push         = sample && (&idx || last);
   // word already includes the bit sampled this cycle, so a push never loses it
   always_comb begin
      word      = assembly;
      word[idx] = scan_out;
   end
   always_ff @(posedge clk or negedge reset_not)
      if (!reset_not) begin
         st            <= IDLE;
         assembly      <= '0;
         wb.word_data  <= '0;
         wb.word_valid <= 1'b0;
         capture_done  <= 1'b0;
         overflow      <= 1'b0;
         bit_cnt       <= '0;
         mismatch_cnt  <= '0;
      end else if (!enable) begin
         st            <= IDLE;
         assembly      <= '0;
         wb.word_data  <= '0;
         wb.word_valid <= 1'b0;
         capture_done  <= 1'b0;
         overflow      <= 1'b0;
         bit_cnt       <= '0;
         mismatch_cnt  <= '0;
      end else begin
         if (wb.word_valid && wb.word_ready) wb.word_valid <= 1'b0;
         if (push) begin
            if (!wb.word_valid || wb.word_ready) begin
               wb.word_data  <= word;
               wb.word_valid <= 1'b1;
            end else overflow <= 1'b1;
         end
         case (st)
            IDLE: if (capture_start) begin
               st           <= CAPTURE;
               assembly     <= '0;
               bit_cnt      <= '0;
               mismatch_cnt <= '0;
               overflow     <= 1'b0;
               capture_done <= 1'b0;
            end
            CAPTURE: if (sample) begin
               assembly <= push ? '0 : word;
               if (scan_out != expected_bit && !(&mismatch_cnt)) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
               if (last) st <= DONE;
               else bit_cnt <= bit_cnt + CNT_W'(1);
            end
            DONE: begin
               capture_done <= 1'b1;
               st           <= IDLE;
            end
            default: st <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_ip2_scanout_capture.sv
// tb_ip2_scanout_capture: directed scenarios for the scan-out capture block with
// hand-computed word, counter and status expectations.
module tb_ip2_scanout_capture;
   logic        clk = 1'b0, reset_not = 1'b0, enable = 1'b1;
   logic        capture_start = 1'b0, scan_out = 1'b0, expected_bit = 1'b0;
   logic [5:0]  clk_counter = '0, sample_phase = 6'd20;
   logic [10:0] bit_cnt_max = '0;
   logic        capture_busy, capture_done, overflow;
   logic [10:0] bit_cnt, mismatch_cnt;
   logic [1:0]  state;
   logic        fast = 1'b1;
   logic [31:0] got[$];
   int          errors = 0, checks = 0;

   ip2_scanout_capture_if #(.WORD_W(32)) wb();

   ip2_scanout_capture #(.WORD_W(32), .CNT_W(11), .PH_W(6)) dut (
      .clk(clk), .reset_not(reset_not), .enable(enable),
      .clk_counter(clk_counter), .sample_phase(sample_phase),
      .capture_start(capture_start), .bit_cnt_max(bit_cnt_max),
      .scan_out(scan_out), .expected_bit(expected_bit), .wb(wb),
      .capture_busy(capture_busy), .capture_done(capture_done), .overflow(overflow),
      .bit_cnt(bit_cnt), .mismatch_cnt(mismatch_cnt), .state(state)
   );

   always #5 clk = ~clk;

   // fast mode parks clk_counter on sample_phase so every cycle is a sample cycle
   task automatic tick();
      @(negedge clk);
      clk_counter = fast ? sample_phase : clk_counter + 6'd1;
   endtask

   function automatic logic pat(input int mode, input int i);
      return mode == 0 ? ~i[0] :
             mode == 1 ? 1'b1 :
             mode == 2 ? (i inside {3, 10, 20, 40, 63}) :
             mode == 3 ? 1'b1 : (i < 32);
   endfunction

   task automatic run(input int max, input int mode, input bit fst, input int ready_at, input int stop_at);
      int i = 0, guard = 0;
      got.delete();
      fast = fst;
      bit_cnt_max = max[10:0];
      wb.word_ready = ready_at == 0;
      tick();
      capture_start = 1'b1;
      tick();
      capture_start = 1'b0;
      while (state != 2'b00 && i < stop_at && guard < 10000) begin
         if (capture_busy && clk_counter == sample_phase) begin
            if (i >= ready_at) wb.word_ready = 1'b1;
            scan_out = pat(mode, i);
            expected_bit = mode < 2 ? scan_out : 1'b0;
            i++;
         end
         if (wb.word_valid && wb.word_ready) got.push_back(wb.word_data);
         tick();
         guard++;
      end
      checks++;
      if (guard >= 10000) begin errors++; $display("FAIL run_timeout: got %0d cycles, required < 10000", guard); end
   endtask

   task automatic test_reset();
      reset_not = 1'b0;
      tick(); tick();
      checks++; if ({state, wb.word_valid, capture_busy, capture_done, overflow} !== 6'b0) begin errors++; $display("FAIL reset_status: got %b required 000000", {state, wb.word_valid, capture_busy, capture_done, overflow}); end
      checks++; if (wb.word_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h required 0", wb.word_data); end
      checks++; if ({bit_cnt, mismatch_cnt} !== 22'h0) begin errors++; $display("FAIL reset_counts: got %0d/%0d required 0/0", bit_cnt, mismatch_cnt); end
      reset_not = 1'b1;
      tick();
   endtask

   task automatic test_full();
      int bad = 0;
      run(1535, 0, 1'b1, 0, 1 << 30);
      foreach (got[k]) if (got[k] !== 32'h5555_5555) bad++;
      checks++; if (got.size() !== 48) begin errors++; $display("FAIL full_words: got %0d words required 48", got.size()); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL full_data: got %0d bad words required 0", bad); end
      checks++; if ({capture_done, overflow} !== 2'b10) begin errors++; $display("FAIL full_status: got done/ovf %b required 10", {capture_done, overflow}); end
      checks++; if (mismatch_cnt !== 11'd0 || bit_cnt !== 11'd1535) begin errors++; $display("FAIL full_counts: got %0d/%0d required 0/1535", mismatch_cnt, bit_cnt); end
   endtask

   task automatic test_partial();
      run(39, 1, 1'b0, 0, 1 << 30);
      checks++; if (got.size() !== 2) begin errors++; $display("FAIL partial_words: got %0d required 2", got.size()); end
      else begin
         checks++; if (got[0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL partial_w0: got %h required ffffffff", got[0]); end
         checks++; if (got[1] !== 32'h0000_00FF) begin errors++; $display("FAIL partial_w1: got %h required 000000ff", got[1]); end
      end
      checks++; if (bit_cnt !== 11'd39 || state !== 2'b00 || capture_done !== 1'b1) begin errors++; $display("FAIL partial_end: got cnt=%0d st=%b done=%b required 39 00 1", bit_cnt, state, capture_done); end
   endtask

   task automatic test_mismatch();
      run(63, 2, 1'b1, 0, 1 << 30);
      checks++; if (mismatch_cnt !== 11'd5) begin errors++; $display("FAIL mismatch_cnt: got %0d required 5", mismatch_cnt); end
      checks++; if (got.size() !== 2 || got[0] !== 32'h0010_0408 || got[1] !== 32'h8000_0100) begin errors++; $display("FAIL mismatch_words: got n=%0d w0=%h required 2 00100408/80000100", got.size(), got.size() > 0 ? got[0] : 32'h0); end
      run(2047, 3, 1'b1, 0, 1 << 30);
      checks++; if (mismatch_cnt !== 11'd2047 || bit_cnt !== 11'd2047) begin errors++; $display("FAIL mismatch_sat: got %0d/%0d required 2047/2047", mismatch_cnt, bit_cnt); end
   endtask

   task automatic test_backpressure();
      run(95, 4, 1'b1, 1 << 30, 1 << 30);
      checks++; if (got.size() !== 0 || wb.word_valid !== 1'b1) begin errors++; $display("FAIL bp_hold: got n=%0d valid=%b required 0 1", got.size(), wb.word_valid); end
      checks++; if (wb.word_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL bp_data: got %h required ffffffff", wb.word_data); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow: got %b required 1", overflow); end
      wb.word_ready = 1'b1;
      tick();
      checks++; if (wb.word_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got valid %b required 0", wb.word_valid); end
   endtask

   task automatic test_back_to_back();
      run(63, 2, 1'b1, 63, 1 << 30);
      checks++; if (got.size() !== 2) begin errors++; $display("FAIL b2b_words: got %0d required 2", got.size()); end
      else begin
         checks++; if (got[0] !== 32'h0010_0408) begin errors++; $display("FAIL b2b_w0: got %h required 00100408", got[0]); end
         checks++; if (got[1] !== 32'h8000_0100) begin errors++; $display("FAIL b2b_w1: got %h required 80000100", got[1]); end
      end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b required 0", overflow); end
   endtask

   task automatic test_abort();
      run(1535, 3, 1'b1, 0, 300);
      checks++; if (bit_cnt !== 11'd300 || mismatch_cnt !== 11'd300) begin errors++; $display("FAIL abort_pre: got %0d/%0d required 300/300", bit_cnt, mismatch_cnt); end
      reset_not = 1'b0;
      #1;
      checks++; if ({state, wb.word_valid, capture_busy, overflow} !== 5'b0 || wb.word_data !== 32'h0 || {bit_cnt, mismatch_cnt} !== 22'h0) begin errors++; $display("FAIL abort_reset: got st=%b data=%h cnt=%0d mm=%0d required all 0", state, wb.word_data, bit_cnt, mismatch_cnt); end
      tick();
      reset_not = 1'b1;
      run(39, 1, 1'b1, 0, 1 << 30);
      checks++; if (got.size() !== 2 || got[1] !== 32'h0000_00FF || bit_cnt !== 11'd39) begin errors++; $display("FAIL abort_restart_rst: got n=%0d cnt=%0d required 2 39", got.size(), bit_cnt); end
      run(1535, 3, 1'b1, 0, 300);
      enable = 1'b0;
      #1;
      checks++; if (bit_cnt !== 11'd300) begin errors++; $display("FAIL abort_en_pre: got %0d required 300", bit_cnt); end
      tick();
      checks++; if ({state, wb.word_valid, capture_busy, capture_done, overflow} !== 6'b0 || wb.word_data !== 32'h0 || {bit_cnt, mismatch_cnt} !== 22'h0) begin errors++; $display("FAIL abort_enable: got st=%b data=%h cnt=%0d mm=%0d required all 0", state, wb.word_data, bit_cnt, mismatch_cnt); end
      enable = 1'b1;
      run(39, 1, 1'b1, 0, 1 << 30);
      checks++; if (got.size() !== 2 || got[1] !== 32'h0000_00FF || bit_cnt !== 11'd39) begin errors++; $display("FAIL abort_restart_en: got n=%0d cnt=%0d required 2 39", got.size(), bit_cnt); end
   endtask

   initial begin
      wb.word_ready = 1'b1;
      test_reset();
      test_full();
      test_partial();
      test_mismatch();
      test_backpressure();
      test_back_to_back();
      test_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ip2_scanout_capture.md
Name: ip2_scanout_capture

Overview:
Receive-side companion to the ip2 scan-chain shift-in sequencer. While a test shifts the ASIC scan chain, this block samples the serial scan_out stream once per bxclk period, at a programmable phase of clk_counter. It packs the samples LSB-first into words and hands them to a downstream buffer over a valid/ready interface. It also counts bits that differ from the expected (shifted-in) bit and reports completion, busy and overflow status.

Parameters:
WORD_W, 32, packed output word width (power of 2)
CNT_W, 11, bit counter width (supports up to 2048 bits; nominal test is 1536)
PH_W, 6, width of clk_counter / sample_phase

Ports:
clk  in  1  FM clock 400MHz (pl_clk1)
reset_not  in  1  asynchronous active-low reset
enable  in  1  block enable; low = synchronous clear to IDLE
clk_counter  in  PH_W  free-running bxclk phase counter, 0..63
sample_phase  in  PH_W  clk_counter value at which scan_out is sampled
capture_start  in  1  single-cycle start pulse (already edge-detected)
bit_cnt_max  in  CNT_W  number of bits to capture minus 1
scan_out  in  1  ASIC scan-chain serial output, already synchronised
expected_bit  in  1  expected value for the current bit, valid at the sample cycle
word_ready  in  1  downstream accepts word_data
word_data  out  WORD_W  packed captured bits; bit i of the stream goes to position i mod WORD_W
word_valid  out  1  word_data holds an unconsumed word
capture_busy  out  1  high in CAPTURE
capture_done  out  1  sticky done flag
overflow  out  1  sticky: a completed word was dropped
bit_cnt  out  CNT_W  bits sampled so far in the current capture
mismatch_cnt  out  CNT_W  count of samples where scan_out != expected_bit; saturates at all-ones
state  out  2  IDLE=00, CAPTURE=01, DONE=10

Behaviour:
- Reset (reset_not low, async) and enable low (sync): state=IDLE. All outputs, the assembly register and counters go to 0.
- IDLE:
  - capture_start=1 -> CAPTURE next cycle.
  - On entry to CAPTURE, clear bit_cnt, mismatch_cnt, overflow, capture_done and the assembly register. word_valid/word_data are not touched.
  - capture_start is ignored in CAPTURE and DONE.
- CAPTURE (sample event = clk_counter==sample_phase, one per 64 clk):
  - Write scan_out into assembly bit bit_cnt[log2(WORD_W)-1:0].
  - Increment mismatch_cnt if scan_out!=expected_bit, unless it is saturated.
  - If bit_cnt[log2(WORD_W)-1:0]==WORD_W-1, or bit_cnt==bit_cnt_max, the word is complete:
    - Push the assembled word, including the bit sampled this cycle.
    - Clear the assembly register. Unfilled upper bits of a final partial word are 0.
  - If bit_cnt==bit_cnt_max -> DONE. Otherwise bit_cnt+1.
  - Each push and the transition to DONE take effect on the clock edge that ends the sample cycle.
- Output register push rules (evaluated on the push cycle):
  - If word_valid==0, or word_valid&word_ready: load word_data and set word_valid=1.
  - Else (word_valid&!word_ready): the new word is dropped, overflow<=1 (sticky), word_data is unchanged.
- Handshake:
  - A transfer occurs when word_valid&word_ready.
  - word_valid falls the next cycle unless a push coincides.
  - word_data is stable while word_valid&!word_ready.
- DONE:
  - capture_done<=1.
  - DONE -> IDLE the next cycle.
  - capture_done stays high until the next capture_start or reset.
- Latency: sample edge -> word_valid high on the following cycle; the last bit's edge -> state=DONE on the following cycle.
- bit_cnt_max=0: exactly one bit is captured, giving one word with only bit0 possibly set.
- Counter width: bit_cnt never wraps, because the capture terminates at bit_cnt_max.
- capture_busy = (state==CAPTURE).

Test Plan:
- Full 1536-bit capture: bit_cnt_max=1535, sample_phase=20, word_ready=1, scan_out=alternating 1,0 starting with 1 -> 48 words of 0x55555555, capture_done=1, overflow=0, mismatch_cnt=0 with expected_bit=scan_out.
- Partial word: bit_cnt_max=39, scan_out=1 -> words 0xFFFFFFFF then 0x000000FF, then DONE->IDLE, bit_cnt=39.
- Mismatch: expected_bit=0, scan_out=1 for exactly 5 of 64 bits -> mismatch_cnt=5; also 2047+ mismatches -> mismatch_cnt saturates at 2047.
- Backpressure: word_ready=0 for the whole 96-bit capture (bit_cnt_max=95) -> first word held, overflow=1; word_data stays equal to word 0.
- Simultaneous transfer+push: word_ready raised exactly on the push cycle -> word_valid stays 1 with the new data, overflow=0.
- reset_not low mid-CAPTURE (bit_cnt=300) -> all outputs 0 immediately. Same test with enable low -> cleared next edge. A new capture_start then begins at bit_cnt=0.
